// File: rtl/bus_addr_pkg.sv
// Shared widths and result encoding for the bridge-to-bus address translation path.
package bus_addr_pkg;

   localparam int BB_ADDR_WIDTH_DEF      = 12;
   localparam int BUS_ADDR_WIDTH_DEF     = 16;
   localparam int BUS_MEM_ADDR_WIDTH_DEF = 12;
   localparam int SEL_WIDTH_DEF          = 1;
   localparam int DEV_ID_WIDTH_DEF       = 4;
   localparam int ERR_CNT_WIDTH_DEF      = 8;

   typedef enum logic {
      XL_OK  = 1'b0,
      XL_ERR = 1'b1
   } xlate_status_e;

   // An entry is legal when it is enabled and the offset does not exceed the entry's limit.
   function automatic xlate_status_e xlate_status(input logic en, input logic off_over_limit);
      return (en && !off_over_limit) ? XL_OK : XL_ERR;
   endfunction

endpackage

// File: rtl/bb_addr_xlate_if.sv
// Request and translated-request handshakes between the bridge, the translator and the bus master.
interface bb_addr_xlate_if
   import bus_addr_pkg::*;
#(
   parameter int BB_ADDR_WIDTH  = BB_ADDR_WIDTH_DEF,
   parameter int BUS_ADDR_WIDTH = BUS_ADDR_WIDTH_DEF
);
   logic                      in_valid;
   logic                      in_ready;
   logic [BB_ADDR_WIDTH-1:0]  in_addr;
   logic                      in_write;
   logic                      out_valid;
   logic                      out_ready;
   logic [BUS_ADDR_WIDTH-1:0] out_addr;
   logic                      out_write;
   logic                      out_err;

   modport slave (
      input  in_valid, in_addr, in_write, out_ready,
      output in_ready, out_valid, out_addr, out_write, out_err
   );

   modport master (
      output in_valid, in_addr, in_write, out_ready,
      input  in_ready, out_valid, out_addr, out_write, out_err
   );
endinterface

// File: rtl/addr_skid_buf.sv
// Two-register valid/ready stage: output register plus one skid entry, in_ready comes straight from a flop.
module addr_skid_buf #(
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;

   assign in_ready = !skid_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!out_valid || out_ready) begin
         // A full skid entry always blocks new input, so it drains first and order is preserved.
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) begin
               out_data <= in_data;
            end
         end
      end else if (in_valid && in_ready) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end
endmodule

// File: rtl/bb_addr_xlate.sv
// Bridge-to-bus address translator: windowed remap table lookup, error flagging and a registered skid output.
module bb_addr_xlate
   import bus_addr_pkg::*;
#(
   parameter int BB_ADDR_WIDTH      = BB_ADDR_WIDTH_DEF,
   parameter int BUS_ADDR_WIDTH     = BUS_ADDR_WIDTH_DEF,
   parameter int BUS_MEM_ADDR_WIDTH = BUS_MEM_ADDR_WIDTH_DEF,
   parameter int SEL_WIDTH          = SEL_WIDTH_DEF,
   parameter int DEV_ID_WIDTH       = DEV_ID_WIDTH_DEF,
   parameter int ERR_CNT_WIDTH      = ERR_CNT_WIDTH_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   bb_addr_xlate_if.slave                 bus,
   input  logic                           cfg_we,
   input  logic [SEL_WIDTH-1:0]           cfg_idx,
   input  logic [DEV_ID_WIDTH-1:0]        cfg_dev,
   input  logic                           cfg_en,
   input  logic [BB_ADDR_WIDTH-SEL_WIDTH-1:0] cfg_limit,
   output logic [ERR_CNT_WIDTH-1:0]       err_cnt
);
   localparam int NUM_WIN   = 2 ** SEL_WIDTH;
   localparam int OFF_W     = BB_ADDR_WIDTH - SEL_WIDTH;
   localparam int PAYLOAD_W = BUS_ADDR_WIDTH + 2;

   typedef struct packed {
      logic                    en;
      logic [DEV_ID_WIDTH-1:0] dev;
      logic [OFF_W-1:0]        limit;
   } entry_t;

   entry_t tbl [NUM_WIN];

   // Identity defaults put the window index at bus bit BUS_MEM_ADDR_WIDTH, matching the fixed legacy map.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_WIN; i++) begin
            tbl[i] <= '{en: 1'b1, dev: DEV_ID_WIDTH'(i), limit: '1};
         end
      end else if (cfg_we) begin
         tbl[cfg_idx] <= '{en: cfg_en, dev: cfg_dev, limit: cfg_limit};
      end
   end

   logic [SEL_WIDTH-1:0]      win;
   logic [OFF_W-1:0]          off;
   entry_t                    ent;
   xlate_status_e             status;
   logic [BUS_ADDR_WIDTH-1:0] xaddr;
   logic [PAYLOAD_W-1:0]      in_payload;
   logic [PAYLOAD_W-1:0]      out_payload;

   assign win    = bus.in_addr[BB_ADDR_WIDTH-1 -: SEL_WIDTH];
   assign off    = bus.in_addr[OFF_W-1:0];
   assign ent    = tbl[win];
   assign status = xlate_status(ent.en, off > ent.limit);

   always_comb begin
      xaddr = '0;
      if (status == XL_OK) begin
         xaddr[BUS_MEM_ADDR_WIDTH +: DEV_ID_WIDTH] = ent.dev;
         xaddr[OFF_W-1:0]                          = off;
      end
   end

   assign in_payload = {bus.in_write, status == XL_ERR, xaddr};

   addr_skid_buf #(
      .WIDTH(PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (in_payload),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_data  (out_payload)
   );

   assign bus.out_write = out_payload[PAYLOAD_W-1];
   assign bus.out_err   = out_payload[PAYLOAD_W-2];
   assign bus.out_addr  = out_payload[BUS_ADDR_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (bus.out_valid && bus.out_ready && bus.out_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_bb_addr_xlate.sv
// Directed bench for bb_addr_xlate: identity map, remap, error paths, stall/skid ordering, counter saturation, reset.
module tb_bb_addr_xlate;
   import bus_addr_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [0:0]  cfg_idx = '0;
   logic [3:0]  cfg_dev = '0;
   logic        cfg_en = 1'b0;
   logic [10:0] cfg_limit = '0;
   logic [7:0]  err_cnt;

   int n_vec = 0;
   int n_err = 0;

   bb_addr_xlate_if #(.BB_ADDR_WIDTH(12), .BUS_ADDR_WIDTH(16)) bus ();

   bb_addr_xlate dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_dev   (cfg_dev),
      .cfg_en    (cfg_en),
      .cfg_limit (cfg_limit),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [0:0] idx, input logic [3:0] dev, input logic en,
                            input logic [10:0] lim);
      cfg_we = 1'b1; cfg_idx = idx; cfg_dev = dev; cfg_en = en; cfg_limit = lim;
      step();
      cfg_we = 1'b0;
   endtask

   logic [11:0] s_addr [4] = '{12'h001, 12'h802, 12'h003, 12'h804};
   logic [15:0] s_exp  [4] = '{16'h0001, 16'h1002, 16'h0003, 16'h1004};

   initial begin
      int sent;
      int got;
      int cyc;

      bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_write = 1'b0; bus.out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready",  bus.in_ready, 1);
      check("rst_out_addr",  bus.out_addr, 0);
      check("rst_out_err",   bus.out_err, 0);
      check("rst_err_cnt",   err_cnt, 0);

      // identity mapping, one cycle latency
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_addr = 12'h805; bus.in_write = 1'b1;
      step();
      check("id_805_valid", bus.out_valid, 1);
      check("id_805_addr",  bus.out_addr, 16'h1005);
      check("id_805_err",   bus.out_err, 0);
      check("id_805_write", bus.out_write, 1);
      bus.in_addr = 12'h005; bus.in_write = 1'b0;
      step();
      check("id_005_addr",  bus.out_addr, 16'h0005);
      check("id_005_write", bus.out_write, 0);
      bus.in_valid = 1'b0;
      step();
      check("idle_valid", bus.out_valid, 0);

      // remap window 1
      cfg_write(1'b1, 4'hA, 1'b1, 11'h7FF);
      bus.in_valid = 1'b1; bus.in_addr = 12'h923;
      step();
      bus.in_valid = 1'b0;
      check("remap_addr", bus.out_addr, 16'hA123);
      check("remap_err",  bus.out_err, 0);

      // offset above limit
      cfg_write(1'b1, 4'hA, 1'b1, 11'h0FF);
      bus.in_valid = 1'b1; bus.in_addr = 12'h923;
      step();
      bus.in_valid = 1'b0;
      check("lim_err",   bus.out_err, 1);
      check("lim_addr",  bus.out_addr, 0);
      check("lim_valid", bus.out_valid, 1);
      step();
      check("lim_cnt", err_cnt, 1);
      // offset equal to limit is legal
      bus.in_valid = 1'b1; bus.in_addr = 12'h8FF;
      step();
      bus.in_valid = 1'b0;
      check("lim_eq_err",  bus.out_err, 0);
      check("lim_eq_addr", bus.out_addr, 16'hA0FF);

      // disabled window
      cfg_write(1'b1, 4'hA, 1'b0, 11'h7FF);
      bus.in_valid = 1'b1; bus.in_addr = 12'h800;
      step();
      bus.in_valid = 1'b0;
      check("dis_err",  bus.out_err, 1);
      check("dis_addr", bus.out_addr, 0);
      step();
      check("dis_cnt", err_cnt, 2);
      bus.in_valid = 1'b1; bus.in_addr = 12'h010;
      step();
      bus.in_valid = 1'b0;
      check("dis_win0_ok", bus.out_err, 0);

      // streaming under a 3-cycle stall
      cfg_write(1'b1, 4'h1, 1'b1, 11'h7FF);
      sent = 0; got = 0; cyc = 0;
      while (got < 4 && cyc < 40) begin
         bus.in_valid  = (sent < 4);
         bus.in_addr   = (sent < 4) ? s_addr[sent] : 12'h000;
         bus.in_write  = (sent % 2 == 1);
         bus.out_ready = (cyc >= 3);
         if (cyc == 2) begin
            check("stream_ready_drop", bus.in_ready, 0);
            check("stream_accepts",    sent, 2);
         end
         if (bus.out_valid && !bus.out_ready) begin
            check("stall_hold_addr",  bus.out_addr, 16'h0001);
            check("stall_hold_write", bus.out_write, 0);
         end
         if (bus.out_valid && bus.out_ready) begin
            check("stream_addr",  bus.out_addr, s_exp[got]);
            check("stream_write", bus.out_write, (got % 2 == 1));
            got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         step();
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("stream_delivered", got, 4);
      step();
      check("stream_no_dup", bus.out_valid, 0);

      // config write and request on the same edge
      bus.out_ready = 1'b1;
      cfg_we = 1'b1; cfg_idx = 1'b1; cfg_dev = 4'h5; cfg_en = 1'b1; cfg_limit = 11'h7FF;
      bus.in_valid = 1'b1; bus.in_addr = 12'h810; bus.in_write = 1'b0;
      step();
      cfg_we = 1'b0;
      check("cfg_same_edge_old", bus.out_addr, 16'h1010);
      bus.in_addr = 12'h811;
      step();
      bus.in_valid = 1'b0;
      check("cfg_next_new", bus.out_addr, 16'h5011);

      // counter saturation
      cfg_write(1'b1, 4'h5, 1'b0, 11'h7FF);
      bus.in_valid = 1'b1; bus.in_addr = 12'hA00;
      repeat (300) step();
      bus.in_valid = 1'b0;
      repeat (2) step();
      check("err_cnt_sat", err_cnt, 255);

      // mid-stream reset with skid full
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_addr = 12'h001;
      step();
      bus.in_addr = 12'h002;
      step();
      check("pre_rst_skid_full", bus.in_ready, 0);
      rst = 1'b1;
      step();
      check("rst_mid_valid",   bus.out_valid, 0);
      check("rst_mid_ready",   bus.in_ready, 1);
      check("rst_mid_err_cnt", err_cnt, 0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      step();
      check("post_rst_idle", bus.out_valid, 0);
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_addr = 12'h923;
      step();
      bus.in_valid = 1'b0;
      check("post_rst_identity", bus.out_addr, 16'h1123);
      check("post_rst_err",      bus.out_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
